// File: rtl/photon_gate_counter_pkg.sv
// Shared definitions for the photon gate counter: FSM states, FIFO word layout
// and parameter limits.
package photon_gate_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        GAP
    } state_t;

    localparam int CH_MSB  = 31;
    localparam int CH_LSB  = 28;
    localparam int SAT_BIT = 27;
    localparam int CNT_MSB = 26;
    localparam int CNT_FIELD_W = CNT_MSB + 1;

    localparam int MAX_N_CH  = 16;
    localparam int MIN_CNT_W = 8;
    localparam int MAX_CNT_W = 27;

    function automatic logic [31:0] make_word(input logic [3:0] ch, input logic sat,
                                              input logic [CNT_MSB:0] cnt);
        logic [31:0] w;
        w = '0;
        w[CH_MSB:CH_LSB] = ch;
        w[SAT_BIT] = sat;
        w[CNT_MSB:0] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/photon_gate_counter_pulse_edge_sync.sv
// One-bit two-flop synchroniser followed by a rising-edge detector.
module pulse_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/photon_gate_counter.sv
// Per-channel photon counters gated by a 50 Hz marker; each closed window is
// snapshotted and drained to a FIFO as one word per channel.
module photon_gate_counter
    import photon_gate_counter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] photon_pulse,
    input  logic            sync_50Hz,
    input  logic            fifo_is_full,
    output logic            wr_fifo,
    output logic [31:0]     dout,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     dropped_frames
);

    if (N_CH < 1 || N_CH > MAX_N_CH || CNT_W < MIN_CNT_W || CNT_W > MAX_CNT_W) begin : g_bad_param
        $error("photon_gate_counter: N_CH or CNT_W out of range");
    end

    localparam logic [3:0] LAST_IDX = 4'(N_CH - 1);

    logic [N_CH-1:0]  pulse_ev;
    logic             sync_ev;

    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  sat;
    logic [CNT_W-1:0] snap_cnt [MAX_N_CH];
    logic [MAX_N_CH-1:0] snap_sat;

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic        wr_n;
    logic [31:0] dout_n;
    logic        frame_done_n;

    for (genvar g = 0; g < N_CH; g++) begin : g_pulse_sync
        pulse_edge_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (photon_pulse[g]),
            .rise  (pulse_ev[g])
        );
    end

    pulse_edge_sync u_gate_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sync_50Hz),
        .rise  (sync_ev)
    );

    // sat marks a pulse that arrived while the counter was already at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
            for (int unsigned i = 0; i < MAX_N_CH; i++) snap_cnt[i] <= '0;
            sat            <= '0;
            snap_sat       <= '0;
            dropped_frames <= '0;
        end else if (!en) begin
            for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
            sat <= '0;
        end else begin
            if (sync_ev) begin
                if (state == IDLE) begin
                    for (int unsigned i = 0; i < N_CH; i++) snap_cnt[i] <= cnt[i];
                    snap_sat[N_CH-1:0] <= sat;
                end else if (dropped_frames != '1) begin
                    dropped_frames <= dropped_frames + 16'd1;
                end
            end
            // A pulse coincident with the gate marker belongs to the new window.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (sync_ev) begin
                    cnt[i] <= {{(CNT_W-1){1'b0}}, pulse_ev[i]};
                    sat[i] <= 1'b0;
                end else if (pulse_ev[i]) begin
                    if (cnt[i] == '1) sat[i] <= 1'b1;
                    else              cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            wr_fifo    <= 1'b0;
            dout       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            wr_fifo    <= wr_n;
            dout       <= dout_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        wr_n         = 1'b0;
        dout_n       = dout;
        frame_done_n = 1'b0;
        if (!en) begin
            state_n = IDLE;
            idx_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sync_ev) begin
                        state_n = CHECK;
                        idx_n   = '0;
                    end
                end
                CHECK: begin
                    if (!fifo_is_full) begin
                        wr_n    = 1'b1;
                        dout_n  = make_word(idx, snap_sat[idx], CNT_FIELD_W'(snap_cnt[idx]));
                        state_n = WRITE;
                    end
                end
                WRITE: state_n = GAP;
                GAP: begin
                    if (idx == LAST_IDX) begin
                        state_n      = IDLE;
                        frame_done_n = 1'b1;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = CHECK;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_photon_gate_counter.sv
// Randomised and directed bench for photon_gate_counter against a
// window/word-queue behavioural model.
module tb_photon_gate_counter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic [N-1:0] photon_pulse = '0;
    logic         sync_50Hz = 1'b0;
    logic         fifo_is_full = 1'b0;
    logic         wr_fifo;
    logic [31:0]  dout;
    logic         busy;
    logic         frame_done;
    logic [15:0]  dropped_frames;

    int checks = 0;
    int errors = 0;

    photon_gate_counter #(.N_CH(N), .CNT_W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .photon_pulse   (photon_pulse),
        .sync_50Hz      (sync_50Hz),
        .fifo_is_full   (fifo_is_full),
        .wr_fifo        (wr_fifo),
        .dout           (dout),
        .busy           (busy),
        .frame_done     (frame_done),
        .dropped_frames (dropped_frames)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: inputs become events two edges after first being
    // sampled high; each accepted window becomes N queued words, written one
    // every third cycle whenever the FIFO is not full.
    logic [N:0]  h1, h2, h3, ev;
    int          mcnt [N];
    bit          msat [N];
    logic [31:0] exp_q [$];
    bit          m_busy, m_wr, m_fd, busy_pre;
    logic [31:0] m_dout;
    int          m_drop;
    int          next_wr, fin_edge, n_written;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            h1 = '0; h2 = '0; h3 = '0;
            for (int c = 0; c < N; c++) begin mcnt[c] = 0; msat[c] = 0; end
            exp_q.delete();
            m_busy = 0; m_wr = 0; m_fd = 0; m_dout = '0; m_drop = 0; n_written = 0;
        end else begin
            ev = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = {sync_50Hz, photon_pulse};
            busy_pre = m_busy;
            m_wr = 0;
            m_fd = 0;
            if (!en) begin
                for (int c = 0; c < N; c++) begin mcnt[c] = 0; msat[c] = 0; end
                exp_q.delete();
                m_busy = 0;
            end else begin
                if (busy_pre) begin
                    if (n_written < N && cyc >= next_wr && !fifo_is_full) begin
                        m_wr = 1;
                        m_dout = exp_q.pop_front();
                        n_written++;
                        next_wr = cyc + 3;
                        if (n_written == N) fin_edge = cyc + 2;
                    end else if (n_written == N && cyc == fin_edge) begin
                        m_busy = 0;
                        m_fd = 1;
                    end
                end
                if (ev[N]) begin
                    if (!busy_pre) begin
                        for (int c = 0; c < N; c++)
                            exp_q.push_back({4'(c), msat[c], 27'(mcnt[c])});
                        m_busy = 1;
                        n_written = 0;
                        next_wr = cyc + 1;
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                    for (int c = 0; c < N; c++) begin
                        mcnt[c] = ev[c] ? 1 : 0;
                        msat[c] = 0;
                    end
                end else begin
                    for (int c = 0; c < N; c++)
                        if (ev[c]) begin
                            if (mcnt[c] == MAXC) msat[c] = 1;
                            else mcnt[c]++;
                        end
                end
            end
        end
    end

    logic [31:0] wlog [$];

    always @(posedge clk) begin
        #1;
        chk("wr_fifo", 32'(wr_fifo), 32'(m_wr));
        chk("dout", dout, m_dout);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("dropped_frames", 32'(dropped_frames), 32'(m_drop));
        if (wr_fifo === 1'b1) wlog.push_back(dout);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_counts(input int k0, input int k1, input int k2, input int k3);
        int k [N];
        int mx;
        k = '{k0, k1, k2, k3};
        mx = 0;
        for (int c = 0; c < N; c++) if (k[c] > mx) mx = k[c];
        for (int i = 0; i < mx; i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) photon_pulse[c] = (k[c] > i);
            @(negedge clk);
            photon_pulse = '0;
        end
        @(negedge clk);
    endtask

    task automatic do_sync();
        @(negedge clk);
        sync_50Hz = 1'b1;
        tick(2);
        sync_50Hz = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string nm);
        bit got;
        got = 0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            got = frame_done;
        end
        chk(nm, 32'(got), 32'd1);
        tick(2);
    endtask

    function automatic logic [31:0] logged(input int i);
        return (i < wlog.size()) ? wlog[i] : 32'hFFFF_FFFF;
    endfunction

    logic [31:0] lit [4];
    int seg_rate;

    initial begin
        tick(3);
        chk("reset_wr_fifo", 32'(wr_fifo), 32'd0);
        chk("reset_dout", dout, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dropped", 32'(dropped_frames), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Basic frame
        wlog.delete();
        pulse_counts(5, 0, 17, 1);
        do_sync();
        wait_done("basic_frame_done");
        lit = '{32'h0000_0005, 32'h1000_0000, 32'h2000_0011, 32'h3000_0001};
        chk("basic_word_count", wlog.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_word%0d", i), logged(i), lit[i]);

        // Saturation, then sat cleared in the next window
        wlog.delete();
        pulse_counts(0, 300, 0, 0);
        do_sync();
        wait_done("sat_frame_done");
        chk("sat_word_ch1", logged(1), 32'h1800_00FF);
        wlog.delete();
        pulse_counts(0, 3, 0, 0);
        do_sync();
        wait_done("unsat_frame_done");
        chk("unsat_word_ch1", logged(1), 32'h1000_0003);

        // FIFO full stall
        wlog.delete();
        pulse_counts(2, 2, 2, 2);
        @(negedge clk);
        fifo_is_full = 1'b1;
        do_sync();
        tick(10);
        chk("full_no_writes", wlog.size(), 32'd0);
        fifo_is_full = 1'b0;
        wait_done("full_frame_done");
        chk("full_word_count", wlog.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("full_word%0d", i), logged(i), 32'h2 | (32'(i) << 28));

        // Dropped frame during drain
        wlog.delete();
        pulse_counts(1, 1, 1, 1);
        do_sync();
        tick(4);
        do_sync();
        wait_done("drop_frame_done");
        chk("dropped_one", 32'(dropped_frames), 32'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("drop_word%0d", i), logged(i), 32'h1 | (32'(i) << 28));

        // Pulse coincident with the gate marker
        do_sync();
        wait_done("flush_frame_done");
        pulse_counts(2, 0, 0, 0);
        wlog.delete();
        @(negedge clk);
        photon_pulse[0] = 1'b1;
        sync_50Hz = 1'b1;
        @(negedge clk);
        photon_pulse[0] = 1'b0;
        tick(1);
        sync_50Hz = 1'b0;
        tick(2);
        wait_done("coinc_old_done");
        chk("coinc_old_ch0", logged(0), 32'h0000_0002);
        wlog.delete();
        do_sync();
        wait_done("coinc_new_done");
        chk("coinc_new_ch0", logged(0), 32'h0000_0001);

        // Reset mid-frame
        pulse_counts(3, 3, 3, 3);
        wlog.delete();
        do_sync();
        for (int t = 0; t < 100 && wlog.size() < 2; t++) @(negedge clk);
        chk("two_writes_before_reset", wlog.size(), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_fifo", 32'(wr_fifo), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_dropped", 32'(dropped_frames), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("no_writes_after_reset", wlog.size(), 32'd2);

        // Enable dropped mid-frame
        pulse_counts(1, 2, 0, 0);
        do_sync();
        tick(4);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        tick(40);

        // Randomised segments with varying gate rates
        for (int s = 0; s < 8; s++) begin
            case (s % 3)
                0: seg_rate = 12;
                1: seg_rate = 40;
                default: seg_rate = 900;
            endcase
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                photon_pulse = N'($urandom);
                sync_50Hz    = ($urandom_range(0, seg_rate - 1) == 0);
                fifo_is_full = ($urandom_range(0, 3) == 0);
                en           = ($urandom_range(0, 299) != 0);
                if (s == 4 && i == 300) rst_n = 1'b0;
                if (s == 4 && i == 303) rst_n = 1'b1;
            end
        end
        @(negedge clk);
        photon_pulse = '0;
        sync_50Hz = 1'b0;
        fifo_is_full = 1'b0;
        en = 1'b1;
        tick(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
